maxpool_scheduler: RTL and testbench
====================================

// Module: maxpool_scheduler
// PURPOSE
//  Sequences a multi-channel 2x2/stride-2 max-pool layer through one shared maxpool_engine.
//  Per channel: flush engine, stream MAP_WIDTH^2 pixels from the source feature-map RAM,
//  collect OUT_DIM^2 results, write them to the destination RAM. Sits between the layer
//  controller (start/done) and the feature-map buffers. Engine has no backpressure; source
//  arbitration loss is expressed via hold.
// PARAMETERS
//  MAP_WIDTH     28                        input map side, even, >=2
//  NUM_CHANNELS  6                         channels pooled per start
//  OUT_DIM       MAP_WIDTH/2               output map side
//  SRC_AW        $clog2(NUM_CHANNELS*MAP_WIDTH**2)  source address width
//  DST_AW        $clog2(NUM_CHANNELS*OUT_DIM**2)    destination address width
// PORTS
//  clk           in   1       clock
//  rst           in   1       sync active-high reset
//  start         in   1       begin layer; sampled in IDLE only
//  hold          in   1       source RAM not granted; suppress read this cycle
//  busy          out  1       high from cycle after start accepted until done pulse
//  done          out  1       1-cycle pulse after last result of last channel written
//  channel_idx   out  $clog2(NUM_CHANNELS)  channel being processed
//  src_rd_en     out  1       source read strobe
//  src_rd_addr   out  SRC_AW  ch*MAP_WIDTH^2 + pixel index (raster order)
//  src_rd_data   in   8       signed; valid exactly 1 cycle after src_rd_en
//  mp_rst        out  1       engine reset/flush
//  mp_valid_in   out  1       to engine valid_in
//  mp_pixel_in   out  8       to engine pixel_in
//  mp_valid_out  in   1       from engine valid_out
//  mp_pixel_out  in   8       from engine pixel_out
//  dst_wr_en     out  1       destination write strobe
//  dst_wr_addr   out  DST_AW  ch*OUT_DIM^2 + output index
//  dst_wr_data   out  8       signed pooled value
// BEHAVIOUR
//  Reset: state IDLE; busy,done,src_rd_en,mp_valid_in,dst_wr_en=0; addrs,data,channel_idx=0;
//   mp_rst=1 while rst high (mp_rst = rst | state==CLEAR).
//  FSM: IDLE -start-> CLEAR (1 cycle, mp_rst=1, pix_cnt=out_cnt=0) -> STREAM
//   STREAM: each cycle hold==0 -> src_rd_en=1, addr=base+pix_cnt, pix_cnt++; hold==1 -> no
//    read, counters frozen. After read of pix MAP_WIDTH^2-1 -> DRAIN.
//   DRAIN: no reads; wait out_cnt==OUT_DIM^2 -> NEXT.
//   NEXT: channel_idx==NUM_CHANNELS-1 -> DONE else channel_idx++ -> CLEAR.
//   DONE: done=1 one cycle, busy falls same edge -> IDLE.
//  Read path: mp_valid_in = src_rd_en delayed 1 cycle; mp_pixel_in = src_rd_data (comb, no
//   extra register). Gaps from hold pass to engine as valid_in=0 bubbles (engine tolerant).
//  Write path: combinational: dst_wr_en=mp_valid_out, dst_wr_data=mp_pixel_out,
//   dst_wr_addr=ch*OUT_DIM^2+out_cnt; out_cnt++ on each mp_valid_out.
//  mp_valid_out outside STREAM/DRAIN: ignored, no write, no count (stale-engine protection).
//  Latency: last engine output arrives 2 cycles after last read (RAM 1 + engine 1); min cycles
//   per channel = 1 CLEAR + MAP_WIDTH^2 STREAM + 2 DRAIN + 1 NEXT.
//  start while busy ignored; start in same cycle as DONE ignored (re-issue next cycle).
//  rst mid-operation: immediate return to IDLE, no done pulse, in-flight results dropped.
//  Widths: addresses computed with SRC_AW/DST_AW unsigned arithmetic; base addresses held in
//   registers incremented by MAP_WIDTH^2 / OUT_DIM^2 in NEXT (no multipliers).
// TESTING (MAP_WIDTH=4, NUM_CHANNELS=2, src[i]=i-16 signed)
//  start, hold=0 -> 16 reads addr 0..15, 4 writes ch0 addr 0..3 = {-11,-9,-3,-1}, then ch1
//   addr 4..7 = {5,7,13,15}; done pulse once; busy high 2*(1+16+2+1)+1 cycles.
//  hold=1 every other cycle in STREAM -> same 8 dst values/addresses, 32 read-phase cycles.
//  start pulsed again while busy -> ignored; exactly one done, 8 writes total.
//  rst asserted mid-STREAM ch1 -> next cycle IDLE, busy=0, no done; new start reruns from ch0
//   addr 0 with identical results.
//  All-negative map (src=-128) -> all 8 writes = -128 (signed compare check).
//  Spurious mp_valid_out injected in IDLE -> no dst_wr_en, out_cnt unchanged.

Source files
------------

// File: rtl/maxpool_scheduler.sv
// Multi-channel 2x2/stride-2 max-pool sequencer driving one shared engine.
// Streams each channel from source RAM, collects results into destination RAM.
module maxpool_scheduler #(
  parameter int MAP_WIDTH    = 28,
  parameter int NUM_CHANNELS = 6,
  parameter int OUT_DIM      = MAP_WIDTH / 2,
  parameter int SRC_AW       = $clog2(NUM_CHANNELS * MAP_WIDTH**2),
  parameter int DST_AW       = $clog2(NUM_CHANNELS * OUT_DIM**2),
  localparam int CW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       channel_idx,
  output logic                src_rd_en,
  output logic [SRC_AW-1:0]   src_rd_addr,
  input  logic signed [7:0]   src_rd_data,
  output logic                mp_rst,
  output logic                mp_valid_in,
  output logic signed [7:0]   mp_pixel_in,
  input  logic                mp_valid_out,
  input  logic signed [7:0]   mp_pixel_out,
  output logic                dst_wr_en,
  output logic [DST_AW-1:0]   dst_wr_addr,
  output logic signed [7:0]   dst_wr_data
);

  localparam int MAP_PIX = MAP_WIDTH * MAP_WIDTH;
  localparam int OUT_PIX = OUT_DIM * OUT_DIM;
  localparam int PW      = (MAP_PIX > 1) ? $clog2(MAP_PIX) : 1;
  localparam int OW      = $clog2(OUT_PIX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [PW-1:0]       pix_q, pix_d;
  logic [OW-1:0]       out_q, out_d;
  logic [SRC_AW-1:0]   src_base_q, src_base_d;
  logic [DST_AW-1:0]   dst_base_q, dst_base_d;
  logic                vin_q;
  logic                rd_en;
  logic                wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      pix_q      <= '0;
      out_q      <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      vin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      pix_q      <= pix_d;
      out_q      <= out_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      vin_q      <= rd_en;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    pix_d      = pix_q;
    out_d      = out_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    rd_en      = 1'b0;
    // Engine outputs outside an active channel are stale; drop them.
    wr_en      = mp_valid_out &&
                 (state_q == S_STREAM || state_q == S_DRAIN);
    if (wr_en) out_d = out_q + OW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        pix_d   = '0;
        out_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (!hold) begin
          rd_en = 1'b1;
          pix_d = pix_q + PW'(1);
          if (pix_q == PW'(MAP_PIX - 1)) begin
            pix_d   = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_d == OW'(OUT_PIX)) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (ch_q == CW'(NUM_CHANNELS - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d       = ch_q + CW'(1);
          src_base_d = src_base_q + SRC_AW'(MAP_PIX);
          dst_base_d = dst_base_q + DST_AW'(OUT_PIX);
          state_d    = S_CLEAR;
        end
      end
      S_DONE: begin
        ch_d       = '0;
        src_base_d = '0;
        dst_base_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign channel_idx = ch_q;
  assign src_rd_en   = rd_en;
  assign src_rd_addr = rd_en ? src_base_q + SRC_AW'(pix_q) : '0;
  assign mp_rst      = rst | (state_q == S_CLEAR);
  assign mp_valid_in = vin_q;
  assign mp_pixel_in = src_rd_data;
  assign dst_wr_en   = wr_en;
  assign dst_wr_addr = wr_en ? dst_base_q + DST_AW'(out_q) : '0;
  assign dst_wr_data = wr_en ? mp_pixel_out : '0;

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Directed bench for maxpool_scheduler with a RAM and 2x2 pooling engine model.
// 4x4 maps, two channels, src[i] = i-16.
module tb_maxpool_scheduler;

  localparam int MW  = 4;
  localparam int NC  = 2;
  localparam int SAW = 5;
  localparam int DAW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic inj = 1'b0;

  logic              busy, done;
  logic [0:0]        channel_idx;
  logic              src_rd_en;
  logic [SAW-1:0]    src_rd_addr;
  logic signed [7:0] src_rd_data;
  logic              mp_rst, mp_valid_in;
  logic signed [7:0] mp_pixel_in;
  logic              mp_valid_out;
  logic signed [7:0] mp_pixel_out;
  logic              dst_wr_en;
  logic [DAW-1:0]    dst_wr_addr;
  logic signed [7:0] dst_wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maxpool_scheduler #(
    .MAP_WIDTH(MW),
    .NUM_CHANNELS(NC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .hold(hold),
    .busy(busy),
    .done(done),
    .channel_idx(channel_idx),
    .src_rd_en(src_rd_en),
    .src_rd_addr(src_rd_addr),
    .src_rd_data(src_rd_data),
    .mp_rst(mp_rst),
    .mp_valid_in(mp_valid_in),
    .mp_pixel_in(mp_pixel_in),
    .mp_valid_out(mp_valid_out),
    .mp_pixel_out(mp_pixel_out),
    .dst_wr_en(dst_wr_en),
    .dst_wr_addr(dst_wr_addr),
    .dst_wr_data(dst_wr_data)
  );

  logic signed [7:0] src_mem [32];

  always @(posedge clk)
    if (src_rd_en) src_rd_data <= src_mem[src_rd_addr];

  // Engine model: raster 4x4 input, 2x2 windows, one-cycle output latency.
  logic [1:0]        er, ec;
  logic signed [7:0] tmp, ep;
  logic signed [7:0] lb [2];
  logic              ev;

  function automatic logic signed [7:0] smax(
    input logic signed [7:0] a,
    input logic signed [7:0] b
  );
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    if (mp_rst) begin
      er <= '0;
      ec <= '0;
      ev <= 1'b0;
    end else begin
      ev <= 1'b0;
      if (mp_valid_in) begin
        if (!er[0]) begin
          if (!ec[0]) tmp <= mp_pixel_in;
          else lb[ec[1]] <= smax(tmp, mp_pixel_in);
        end else begin
          if (!ec[0]) tmp <= smax(lb[ec[1]], mp_pixel_in);
          else begin
            ev <= 1'b1;
            ep <= smax(tmp, mp_pixel_in);
          end
        end
        ec <= ec + 2'd1;
        if (ec == 2'd3) er <= er + 2'd1;
      end
    end
  end

  assign mp_valid_out = ev | inj;
  assign mp_pixel_out = inj ? 8'sd77 : ep;

  int rd_log[$];
  int rd_t[$];
  int wa_log[$];
  int wd_log[$];
  int done_cnt = 0;
  int tick = 0;

  always @(negedge clk) begin
    tick++;
    if (src_rd_en) begin
      rd_log.push_back(int'(src_rd_addr));
      rd_t.push_back(tick);
    end
    if (dst_wr_en) begin
      wa_log.push_back(int'(dst_wr_addr));
      wd_log.push_back(int'(dst_wr_data));
    end
    if (done) done_cnt++;
  end

  int exp_d [8] = '{-11, -9, -3, -1, 5, 7, 13, 15};

  task automatic clear_logs();
    rd_log.delete();
    rd_t.delete();
    wa_log.delete();
    wd_log.delete();
    done_cnt = 0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 32; i++) src_mem[i] = 8'(i - 16);
  endtask

  task automatic run_layer(input bit hmode, input bit smode,
                           output int cyc, output bit to);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (busy && cyc < 500) begin
      hold  = hmode & cyc[0];
      start = smode && (cyc == 5 || cyc == 40);
      @(posedge clk); #1;
      cyc++;
    end
    hold  = 1'b0;
    start = 1'b0;
    to    = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done got %b%b want 00", busy, done);
    end
    checks++;
    if (src_rd_en !== 1'b0 || dst_wr_en !== 1'b0 || mp_valid_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b%b%b want 000",
               src_rd_en, dst_wr_en, mp_valid_in);
    end
    checks++;
    if (channel_idx !== 1'b0 || src_rd_addr !== '0 || dst_wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_idx_addr got %0d %0d %0d want 0 0 0",
               channel_idx, src_rd_addr, dst_wr_addr);
    end
    checks++;
    if (mp_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_mp_rst got %b want 1", mp_rst);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mp_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got mp_rst=%b busy=%b want 0 0", mp_rst, busy);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit to;
    clear_logs();
    run_layer(1'b0, 1'b0, cyc, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout busy=%b want 0", busy);
    end
    checks++;
    if (cyc !== 41) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 41", cyc);
    end
    checks++;
    if (rd_log.size() !== 32) begin
      errors++;
      $display("FAIL basic_read_count got %0d want 32", rd_log.size());
    end
    for (int i = 0; i < rd_log.size() && i < 32; i++) begin
      checks++;
      if (rd_log[i] !== i) begin
        errors++;
        $display("FAIL basic_read_addr[%0d] got %0d want %0d", i, rd_log[i], i);
      end
    end
    checks++;
    if (wa_log.size() !== 8) begin
      errors++;
      $display("FAIL basic_write_count got %0d want 8", wa_log.size());
    end
    for (int i = 0; i < wa_log.size() && i < 8; i++) begin
      checks++;
      if (wa_log[i] !== i || wd_log[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_write[%0d] got a=%0d d=%0d want a=%0d d=%0d",
                 i, wa_log[i], wd_log[i], i, exp_d[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL basic_done_count got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_hold();
    int cyc;
    bit to;
    clear_logs();
    run_layer(1'b1, 1'b0, cyc, to);
    checks++;
    if (to || cyc !== 73) begin
      errors++;
      $display("FAIL hold_busy_cycles got %0d (timeout %b) want 73", cyc, to);
    end
    checks++;
    if (rd_log.size() !== 32) begin
      errors++;
      $display("FAIL hold_read_count got %0d want 32", rd_log.size());
    end else begin
      checks++;
      if (rd_t[15] - rd_t[0] !== 30) begin
        errors++;
        $display("FAIL hold_read_span got %0d want 30", rd_t[15] - rd_t[0]);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (rd_log[i] !== i) begin
          errors++;
          $display("FAIL hold_read_addr[%0d] got %0d want %0d", i, rd_log[i], i);
        end
      end
    end
    checks++;
    if (wa_log.size() !== 8) begin
      errors++;
      $display("FAIL hold_write_count got %0d want 8", wa_log.size());
    end
    for (int i = 0; i < wa_log.size() && i < 8; i++) begin
      checks++;
      if (wa_log[i] !== i || wd_log[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL hold_write[%0d] got a=%0d d=%0d want a=%0d d=%0d",
                 i, wa_log[i], wd_log[i], i, exp_d[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL hold_done_count got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_double_start();
    int cyc;
    bit to;
    clear_logs();
    run_layer(1'b0, 1'b1, cyc, to);
    checks++;
    if (to || cyc !== 41) begin
      errors++;
      $display("FAIL dstart_busy_cycles got %0d (timeout %b) want 41", cyc, to);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL dstart_start_in_done got busy=%b want 0", busy);
    end
    checks++;
    if (done_cnt !== 1 || wa_log.size() !== 8) begin
      errors++;
      $display("FAIL dstart_counts got done=%0d writes=%0d want 1 8",
               done_cnt, wa_log.size());
    end
  endtask

  task automatic test_midreset();
    int cyc;
    bit to;
    clear_logs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
    end
    checks++;
    if (channel_idx !== 1'b1 || src_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL mreset_precond got ch=%0d rd=%b want 1 1",
               channel_idx, src_rd_en);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || channel_idx !== 1'b0 || src_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL mreset_idle got busy=%b ch=%0d rd=%b want 0 0 0",
               busy, channel_idx, src_rd_en);
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt !== 0 || wa_log.size() !== 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mreset_no_done got done=%0d writes=%0d busy=%b want 0 4 0",
               done_cnt, wa_log.size(), busy);
    end
    clear_logs();
    run_layer(1'b0, 1'b0, cyc, to);
    checks++;
    if (to || wa_log.size() !== 8 || done_cnt !== 1) begin
      errors++;
      $display("FAIL mreset_rerun got writes=%0d done=%0d timeout=%b want 8 1 0",
               wa_log.size(), done_cnt, to);
    end
    for (int i = 0; i < wa_log.size() && i < 8; i++) begin
      checks++;
      if (wa_log[i] !== i || wd_log[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL mreset_write[%0d] got a=%0d d=%0d want a=%0d d=%0d",
                 i, wa_log[i], wd_log[i], i, exp_d[i]);
      end
    end
  endtask

  task automatic test_negative();
    int cyc;
    bit to;
    for (int i = 0; i < 32; i++) src_mem[i] = -8'sd128;
    clear_logs();
    run_layer(1'b0, 1'b0, cyc, to);
    checks++;
    if (to || wa_log.size() !== 8) begin
      errors++;
      $display("FAIL neg_write_count got %0d timeout=%b want 8", wa_log.size(), to);
    end
    for (int i = 0; i < wa_log.size() && i < 8; i++) begin
      checks++;
      if (wa_log[i] !== i || wd_log[i] !== -128) begin
        errors++;
        $display("FAIL neg_write[%0d] got a=%0d d=%0d want a=%0d d=-128",
                 i, wa_log[i], wd_log[i], i);
      end
    end
    fill_ramp();
  endtask

  task automatic test_spurious();
    int cyc;
    bit to;
    clear_logs();
    @(posedge clk); #1 inj = 1'b1;
    #2;
    checks++;
    if (dst_wr_en !== 1'b0 || dst_wr_addr !== '0) begin
      errors++;
      $display("FAIL spur_idle_write got en=%b a=%0d want 0 0", dst_wr_en, dst_wr_addr);
    end
    @(posedge clk); #1 inj = 1'b0;
    run_layer(1'b0, 1'b0, cyc, to);
    checks++;
    if (to || wa_log.size() !== 8) begin
      errors++;
      $display("FAIL spur_write_count got %0d timeout=%b want 8", wa_log.size(), to);
    end
    for (int i = 0; i < wa_log.size() && i < 8; i++) begin
      checks++;
      if (wa_log[i] !== i || wd_log[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL spur_write[%0d] got a=%0d d=%0d want a=%0d d=%0d",
                 i, wa_log[i], wd_log[i], i, exp_d[i]);
      end
    end
  endtask

  initial begin
    fill_ramp();
    test_reset();
    test_basic();
    test_hold();
    test_double_start();
    test_midreset();
    test_negative();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
